ddr_read_arbiter: RTL and testbench
===================================

# ddr_read_arbiter

Shares one 64-bit DDR read port (Avalon-MM, single-beat) between two toggle-handshake requesters: the ALSA audio fetcher on port 0 and a second low-rate reader (OSD/scaler line fetch) on port 1. It converts each toggle request into one Avalon read, returns the data with a one-cycle ready pulse, and recovers from a memory that never answers. It sits in `sys/` between the requesters and the HPS DDR bridge, in the requesters' clock domain.

## Interface
- `TIMEOUT`, 1023: cycles to wait for `mem_readdatavalid` after the read is accepted before aborting.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_address`  in  [31:3]  port 0 qword address; sampled on grant.
- `req0_req`  in  1  port 0 request; each toggle is one request.
- `req0_ready`  out  1  one-cycle pulse when `req0_data` is valid.
- `req0_data`  out  64  port 0 read data; holds until next ready.
- `req1_address`, `req1_req`, `req1_ready`, `req1_data`: identical for port 1.
- `mem_address`  out  [31:3]  Avalon read address.
- `mem_burstcount`  out  8  constant 1.
- `mem_read`  out  1  Avalon read strobe.
- `mem_waitrequest`  in  1  Avalon stall.
- `mem_readdatavalid`  in  1  Avalon return strobe.
- `mem_readdata`  in  64  Avalon return data.
- `busy`  out  1  high whenever state is not IDLE.
- `err`  out  1  sticky: timeout or stray `mem_readdatavalid` occurred; cleared only by reset.

## Operation
- Per port: `ack` register; `pending = req ^ ack`. On ready pulse `ack <= req` value latched at grant. One outstanding request per port; a second toggle before ready cancels the first (protocol violation, not detected).
- States: IDLE, ISSUE, WAIT.
- IDLE: if any pending, select winner, latch `mem_address <= reqN_address`, record `grant`, `mem_read <= 1`, go ISSUE. Stray `mem_readdatavalid` in IDLE or ISSUE: dropped, `err <= 1`.
- Selection (default): round-robin; both pending -> port not served last; `last` resets to 1 (port 0 wins first tie).
- ISSUE: hold `mem_read` and address until `!mem_waitrequest`; then `mem_read <= 0`, clear timeout counter, go WAIT. No timeout during ISSUE.
- WAIT: on `mem_readdatavalid`: `reqG_data <= mem_readdata`, `reqG_ready <= 1` for one cycle, `ackG` updated, `last <= grant`, go IDLE. Timeout counter increments each WAIT cycle; reaching `TIMEOUT`: `reqG_data <= 0`, ready pulse as normal, `err <= 1`, go IDLE.
- Counter width `$clog2(TIMEOUT+1)`; no wrap.
- Reset values: `mem_read`, `mem_address`, `req*_ready`, `req*_data`, `busy`, `err` all 0; `ack` 0; state IDLE. Reset mid-transaction abandons it; a late beat afterwards is stray (sets `err`). Requesters' toggles reset to 0.

## Timing
- Toggle seen at edge N -> `mem_read` high from N+1 (IDLE has no extra cycle).
- Accept edge A (`mem_read & !mem_waitrequest`) -> `mem_read` low from A+1.
- `mem_readdatavalid` at edge M -> `reqG_ready` and data valid during cycle M+1; IDLE at M+1, next grant may issue `mem_read` from M+2.
- Minimum request-to-ready: 3 cycles with zero wait and readdatavalid on A+1.
- Timeout ready at WAIT entry + `TIMEOUT` cycles.
- Requester toggling at same edge as its ready pulse: new request seen next cycle, serviced normally.

## Configuration
- `DDR_ARB_PRIORITY_EN` defined: port 0 always wins when both pending (audio never waits behind port 1 beyond one in-flight read); `last` unused.
- Undefined: round-robin as above.

## Structure
- Package `ddr_arb_pkg`: state enum (IDLE, ISSUE, WAIT), `MEM_BURST = 8'd1`, port index type.
- Sub-module `toggle_req_port`: `ack`/`pending`, latched ready pulse and data register; instantiated twice; top holds FSM, arbitration, timeout.

## Test plan
- Port 0 toggles, zero waitrequest, data 64'h1122334455667788 on A+1 -> `mem_read` at N+1, `req0_ready` one cycle, `req0_data` matches, `req1_ready` stays 0.
- Both toggle same cycle, twice in a row -> grants 0,1,0,1 (default); with `DDR_ARB_PRIORITY_EN` and port 0 re-toggling on each ready -> port 0 every time while pending.
- `mem_waitrequest` high 5 cycles -> `mem_read` and address stable all 5, exactly one accepted read.
- No readdatavalid, `TIMEOUT=16` -> ready at WAIT+16 with data 0, `err=1`, next request serviced normally.
- Reset asserted in WAIT, beat arrives after release -> all outputs 0 during reset, beat dropped, `err=1`, no ready pulse.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR read arbiter: FSM state encoding, fixed burst size, port index.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic [7:0] MEM_BURST = 8'd1;

  typedef logic port_idx_t;

endpackage

// File: rtl/ddr_read_arbiter_toggle_req_port.sv
// One toggle-handshake requester port: ack/pending tracking, ready pulse and held read data.
module toggle_req_port
  import ddr_arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_take,
  input  logic        i_done,
  input  logic [63:0] i_done_data,
  output logic        o_pending,
  output logic        o_ready,
  output logic [63:0] o_data
);

  logic        r_ack;
  logic        r_req_lat;
  logic        r_ready;
  logic [63:0] r_data;

  assign o_pending = i_req ^ r_ack;
  assign o_ready   = r_ready;
  assign o_data    = r_data;

  // The toggle value is captured at grant so a late re-toggle is not acked early.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack     <= 1'b0;
      r_req_lat <= 1'b0;
      r_ready   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_ready <= i_done;
      if (i_take) r_req_lat <= i_req;
      if (i_done) begin
        r_ack  <= r_req_lat;
        r_data <= i_done_data;
      end
    end
  end

endmodule

// File: rtl/ddr_read_arbiter.sv
// Two-port toggle-request arbiter onto a single-beat Avalon-MM read port with timeout recovery.
// Build option: DDR_ARB_PRIORITY_EN gives port 0 fixed priority instead of round-robin.
module ddr_read_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:3] req0_address,
  input  logic        req0_req,
  output logic        req0_ready,
  output logic [63:0] req0_data,
  input  logic [31:3] req1_address,
  input  logic        req1_req,
  output logic        req1_ready,
  output logic [63:0] req1_data,
  output logic [31:3] mem_address,
  output logic [7:0]  mem_burstcount,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [63:0] mem_readdata,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       r_state;
  port_idx_t        r_grant;
  logic [31:3]      r_mem_address;
  logic             r_mem_read;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic        w_pend0, w_pend1, w_any;
  port_idx_t   w_winner;
  logic        w_take, w_tmo, w_done;
  logic [63:0] w_done_data;

  assign w_any       = w_pend0 | w_pend1;
  assign w_take      = (r_state == ST_IDLE) & w_any;
  assign w_tmo       = (r_cnt == CNT_LAST);
  assign w_done      = (r_state == ST_WAIT) & (mem_readdatavalid | w_tmo);
  assign w_done_data = mem_readdatavalid ? mem_readdata : '0;

`ifdef DDR_ARB_PRIORITY_EN
  assign w_winner = w_pend0 ? 1'b0 : 1'b1;
`else
  logic r_last;

  // A tie goes to the port not served last; reset value 1 lets port 0 win the first tie.
  assign w_winner = (w_pend0 & w_pend1) ? ~r_last : w_pend1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_last <= 1'b1;
    else if (w_done) r_last <= r_grant;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= 1'b0;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_err         <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_readdatavalid) r_err <= 1'b1;
          if (w_any) begin
            r_mem_address <= w_winner ? req1_address : req0_address;
            r_grant       <= w_winner;
            r_mem_read    <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_readdatavalid) r_err <= 1'b1;
          if (!mem_waitrequest) begin
            r_mem_read <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A beat arriving on the timeout cycle still counts as a normal return.
          if (mem_readdatavalid) begin
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  toggle_req_port u_port0 (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_req       (req0_req),
    .i_take      (w_take & (w_winner == 1'b0)),
    .i_done      (w_done & (r_grant == 1'b0)),
    .i_done_data (w_done_data),
    .o_pending   (w_pend0),
    .o_ready     (req0_ready),
    .o_data      (req0_data)
  );

  toggle_req_port u_port1 (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_req       (req1_req),
    .i_take      (w_take & (w_winner == 1'b1)),
    .i_done      (w_done & (r_grant == 1'b1)),
    .i_done_data (w_done_data),
    .o_pending   (w_pend1),
    .o_ready     (req1_ready),
    .o_data      (req1_data)
  );

  assign mem_address    = r_mem_address;
  assign mem_burstcount = MEM_BURST;
  assign mem_read       = r_mem_read;
  assign busy           = (r_state != ST_IDLE);
  assign err            = r_err;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter: latency, arbitration order, stalls, timeout and reset abandon.
module tb_ddr_read_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:3] req0_address, req1_address;
  logic        req0_req, req1_req;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_data, req1_data;
  logic [31:3] mem_address;
  logic [7:0]  mem_burstcount;
  logic        mem_read;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [63:0] mem_readdata;
  logic        busy, err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int accept_cnt = 0;

  logic [28:0] addr0 = 29'h00ABCDEF;
  logic [28:0] addr1 = 29'h01234567;

  ddr_read_arbiter #(.TIMEOUT(TMO)) dut (
    .clk               (clk),
    .reset             (reset),
    .req0_address      (req0_address),
    .req0_req          (req0_req),
    .req0_ready        (req0_ready),
    .req0_data         (req0_data),
    .req1_address      (req1_address),
    .req1_req          (req1_req),
    .req1_ready        (req1_ready),
    .req1_data         (req1_data),
    .mem_address       (mem_address),
    .mem_burstcount    (mem_burstcount),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .busy              (busy),
    .err               (err),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read && !mem_waitrequest) accept_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_req = 1'b0;
    req1_req = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // driver: wait (bounded) for mem_read, called at a negedge
  task automatic wait_mem_read();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mem_read_seen", 64'(ok), 64'd1);
  endtask

  // driver + memory responder for one read; checks which port gets the data
  task automatic serve_read(input int exp_port, input int wait_cycles,
                            input logic [63:0] rdata, input bit retoggle0);
    logic [28:0] ea;
    int acc0;
    ea = (exp_port != 0) ? addr1 : addr0;
    wait_mem_read();
    check("grant_addr", 64'(mem_address), 64'(ea));
    acc0 = accept_cnt;
    for (int i = 0; i < wait_cycles; i++) begin
      mem_waitrequest = 1'b1;
      @(negedge clk);
      check("stall_read", 64'(mem_read), 64'd1);
      check("stall_addr", 64'(mem_address), 64'(ea));
    end
    mem_waitrequest = 1'b0;
    @(negedge clk);
    check("read_drop", 64'(mem_read), 64'd0);
    check("one_accept", 64'(accept_cnt - acc0), 64'd1);
    mem_readdatavalid = 1'b1;
    mem_readdata = rdata;
    @(negedge clk);
    mem_readdatavalid = 1'b0;
    check("ready_vec", 64'({req1_ready, req0_ready}), (exp_port != 0) ? 64'd2 : 64'd1);
    check("ready_data", (exp_port != 0) ? req1_data : req0_data, rdata);
    if (retoggle0) req0_req = ~req0_req;
    @(negedge clk);
    check("ready_pulse_end", 64'({req1_ready, req0_ready}), 64'd0);
  endtask

  int exp_seq[4];
  int rt;
  bit early;
  logic [63:0] bench_data;

  initial begin
    req0_address = addr0;
    req1_address = addr1;
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_addr", 64'(mem_address), 64'd0);
    check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    check("rst_data0", req0_data, 64'd0);
    check("rst_busy_err", 64'({busy, err}), 64'd0);
    check("burstcount", 64'(mem_burstcount), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // port 0 single read, zero wait: mem_read one cycle after the toggle is seen
    req0_req = ~req0_req;
    @(negedge clk);
    check("t1_read_n1", 64'(mem_read), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    serve_read(0, 0, 64'h1122334455667788, 1'b0);
    check("t1_idle", 64'({busy, err}), 64'd0);

    // both toggle together twice: 0,1,0,1
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req0_req = ~req0_req;
      req1_req = ~req1_req;
      @(negedge clk);
      serve_read(0, 0, 64'hA000_0000_0000_0000 | 64'(r), 1'b0);
      serve_read(1, 0, 64'hB000_0000_0000_0000 | 64'(r), 1'b0);
    end
    check("t2_idle", 64'(busy), 64'd0);

    // port 0 re-toggles on its ready while port 1 waits
`ifdef DDR_ARB_PRIORITY_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 0};
`endif
    rt = 0;
    req0_req = ~req0_req;
    req1_req = ~req1_req;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bench_data = 64'hC0DE_0000_0000_0000 | 64'(k);
      serve_read(exp_seq[k], 0, bench_data, (exp_seq[k] == 0) && (rt < 2));
      if ((exp_seq[k] == 0) && (rt < 2)) rt++;
    end
    check("t2b_idle", 64'(busy), 64'd0);

    // waitrequest held 5 cycles on port 1
    req1_req = ~req1_req;
    @(negedge clk);
    serve_read(1, 5, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);

    // no readdatavalid: timeout after TMO cycles in WAIT
    req1_req = ~req1_req;
    @(negedge clk);
    wait_mem_read();
    check("tmo_addr", 64'(mem_address), 64'(addr1));
    @(negedge clk);
    check("tmo_read_drop", 64'(mem_read), 64'd0);
    check("tmo_err_before", 64'(err), 64'd0);
    early = 1'b0;
    repeat (TMO - 1) begin
      @(negedge clk);
      if (req1_ready) early = 1'b1;
    end
    check("tmo_not_early", 64'(early), 64'd0);
    @(negedge clk);
    check("tmo_ready", 64'({req1_ready, req0_ready}), 64'd2);
    check("tmo_data", req1_data, 64'd0);
    check("tmo_err", 64'(err), 64'd1);
    @(negedge clk);
    req0_req = ~req0_req;
    @(negedge clk);
    serve_read(0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
    check("tmo_err_sticky", 64'(err), 64'd1);

    // reset in WAIT, beat arrives after release
    do_reset();
    req0_req = ~req0_req;
    @(negedge clk);
    wait_mem_read();
    @(negedge clk);
    check("rw_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    req0_req = 1'b0;
    req1_req = 1'b0;
    @(negedge clk);
    check("rw_mem", 64'({mem_read, mem_address}), 64'd0);
    check("rw_ready_busy_err", 64'({req1_ready, req0_ready, busy, err}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    mem_readdatavalid = 1'b1;
    mem_readdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    mem_readdatavalid = 1'b0;
    check("rw_stray_err", 64'(err), 64'd1);
    check("rw_no_ready", 64'({req1_ready, req0_ready}), 64'd0);
    check("rw_data0", req0_data, 64'd0);
    check("rw_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("rw_no_ready_late", 64'({req1_ready, req0_ready}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
